// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU with flags and multi-cycle shift-add multiply
module alu_pipe #(
    parameter int D_WIDTH = 8,
    parameter int SHW     = $clog2(D_WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] opA,
    input  logic [D_WIDTH-1:0] opB,
    input  logic [2:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               ovf,
    output logic               neg
);

    localparam logic [2:0]         OP_ADD   = 3'b000;
    localparam logic [2:0]         OP_SUB   = 3'b001;
    localparam logic [2:0]         OP_AND   = 3'b010;
    localparam logic [2:0]         OP_OR    = 3'b011;
    localparam logic [2:0]         OP_XOR   = 3'b100;
    localparam logic [2:0]         OP_SHL   = 3'b101;
    localparam logic [2:0]         OP_SHR   = 3'b110;
    localparam logic [2:0]         OP_MUL   = 3'b111;
    localparam logic [D_WIDTH-1:0] SHIFT_LIM = D_WIDTH'(D_WIDTH);
    localparam logic [SHW-1:0]     CNT_LAST  = SHW'(D_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2*D_WIDTH-1:0] mcand;
    logic [2*D_WIDTH-1:0] prod;
    logic [D_WIDTH-1:0]   mplier;
    logic [SHW-1:0]       cnt;

    logic [D_WIDTH:0]   sum;
    logic [D_WIDTH:0]   diff;
    logic               shift_big;
    logic [D_WIDTH-1:0] alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               accept;
    logic               out_free;

    assign out_free = !out_valid || out_ready;
    assign in_ready = rst_n && (state == ST_IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    assign sum       = {1'b0, opA} + {1'b0, opB};
    assign diff      = {1'b0, opA} - {1'b0, opB};
    assign shift_big = (opB >= SHIFT_LIM);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = sum[D_WIDTH-1:0];
                alu_carry = sum[D_WIDTH];
                alu_ovf   = (opA[D_WIDTH-1] == opB[D_WIDTH-1]) &&
                            (sum[D_WIDTH-1] != opA[D_WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff[D_WIDTH-1:0];
                alu_carry = diff[D_WIDTH];
                alu_ovf   = (opA[D_WIDTH-1] != opB[D_WIDTH-1]) &&
                            (diff[D_WIDTH-1] != opA[D_WIDTH-1]);
            end
            OP_AND: alu_res = opA & opB;
            OP_OR:  alu_res = opA | opB;
            OP_XOR: alu_res = opA ^ opB;
            OP_SHL: alu_res = shift_big ? '0 : (opA << opB[SHW-1:0]);
            OP_SHR: alu_res = shift_big ? '0 : (opA >> opB[SHW-1:0]);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && opcode == OP_MUL) state_nxt = ST_MUL;
            ST_MUL:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: if (out_free) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            neg       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            // A later load in this block overrides the consume-clear.
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (opcode == OP_MUL) begin
                            mcand  <= {{D_WIDTH{1'b0}}, opA};
                            mplier <= opB;
                            prod   <= '0;
                            cnt    <= '0;
                        end else begin
                            result    <= alu_res;
                            carry     <= alu_carry;
                            ovf       <= alu_ovf;
                            zero      <= (alu_res == '0);
                            neg       <= alu_res[D_WIDTH-1];
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                ST_DONE: begin
                    if (out_free) begin
                        result    <= prod[D_WIDTH-1:0];
                        carry     <= |prod[2*D_WIDTH-1:D_WIDTH];
                        ovf       <= 1'b0;
                        zero      <= (prod[D_WIDTH-1:0] == '0);
                        neg       <= prod[D_WIDTH-1];
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] opA = '0;
    logic [7:0] opB = '0;
    logic [2:0] opcode = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       carry, zero, ovf, neg;

    int n_cmp = 0;
    int n_bad = 0;

    alu_pipe #(.D_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opA(opA), .opB(opB), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .ovf(ovf), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, carry, zero, ovf, neg};
    endfunction

    // ef = {carry, zero, ovf, neg}; elat = edges after the accept edge until out_valid.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef,
                          input int elat);
        int wt;
        int lat;
        int lows;
        out_ready = 1'b1;
        wt = 0;
        while (!in_ready && wt < 50) begin
            @(posedge clk); #1; wt++;
        end
        chk({tag, " ready"}, {31'd0, in_ready}, 32'd1);
        opcode = op; opA = a; opB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; opA = 8'hAA; opB = 8'h55; opcode = 3'b010;
        lat = 0; lows = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) lows++;
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " result"}, {24'd0, result}, {24'd0, er});
        chk({tag, " flags"}, flags(), {28'd0, ef});
        if (op == 3'b111) chk({tag, " busy"}, lows, 9);
    endtask

    initial begin
        int spur;
        @(posedge clk); #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst result", {24'd0, result}, 32'd0);
        chk("rst flags", flags(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100, 0);
        run_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011, 0);
        run_op("sub_03_05", 3'b001, 8'h03, 8'h05, 8'hFE, 4'b1001, 0);
        run_op("sub_80_01", 3'b001, 8'h80, 8'h01, 8'h7F, 4'b0010, 0);
        run_op("and",       3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0);
        run_op("or",        3'b011, 8'hF0, 8'h0C, 8'hFC, 4'b0001, 0);
        run_op("xor",       3'b100, 8'hFF, 8'hFF, 8'h00, 4'b0100, 0);
        run_op("shl_1",     3'b101, 8'h81, 8'h01, 8'h02, 4'b0000, 0);
        run_op("shl_8",     3'b101, 8'h81, 8'h08, 8'h00, 4'b0100, 0);
        run_op("shr_7",     3'b110, 8'h80, 8'h07, 8'h01, 4'b0000, 0);
        run_op("shr_16",    3'b110, 8'hFF, 8'h10, 8'h00, 4'b0100, 0);
        run_op("mul_10_20", 3'b111, 8'h10, 8'h20, 8'h00, 4'b1100, 9);
        run_op("mul_0c_0b", 3'b111, 8'h0C, 8'h0B, 8'h84, 4'b0001, 9);

        // Streaming: three ADDs on consecutive edges.
        out_ready = 1'b1; opcode = 3'b000; in_valid = 1'b1;
        opA = 8'h01; opB = 8'h02;
        @(posedge clk); #1;
        chk("stream0 result", {24'd0, result}, 32'h03);
        chk("stream0 in_ready", {31'd0, in_ready}, 32'd1);
        opA = 8'h10; opB = 8'h20;
        @(posedge clk); #1;
        chk("stream1 result", {24'd0, result}, 32'h30);
        opA = 8'h40; opB = 8'h40;
        @(posedge clk); #1;
        chk("stream2 result", {24'd0, result}, 32'h80);
        chk("stream2 flags", flags(), 32'b0011);
        chk("stream2 valid", {31'd0, out_valid}, 32'd1);

        // Back-pressure: offered op must be ignored while the result is held.
        out_ready = 1'b0; opA = 8'h01; opB = 8'h01;
        #1;
        chk("bp in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp hold result", {24'd0, result}, 32'h80);
            chk("bp hold valid", {31'd0, out_valid}, 32'd1);
        end
        // Consume and accept on the same edge.
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("swap result", {24'd0, result}, 32'h02);
        chk("swap valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a multiply.
        opcode = 3'b111; opA = 8'h0C; opB = 8'h0B; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst valid", {31'd0, out_valid}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst result", {24'd0, result}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        spur = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) spur++;
        end
        chk("midrst spurious", spur, 0);
        chk("midrst idle", {31'd0, in_ready}, 32'd1);
        run_op("post_rst_add", 3'b000, 8'h05, 8'h03, 8'h08, 4'b0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
